// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle for the hazard controller: register addresses and
// control bits coming from each stage, plus forwarding selects, pipeline
// register enables and statistics going back.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ra1_d, ra2_d, ra3_d;
  logic [3:0]       ra1_e, ra2_e, ra3_e;
  logic [3:0]       wa_e, wa_m, wa_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic             mem_reg_e;
  logic             pc_src_d, pc_src_w;
  logic             branch_taken_e;
  logic [1:0]       fwd_a_e, fwd_b_e, fwd_c_e;
  logic             stall_f, stall_d;
  logic             flush_d, flush_e;
  logic             pc_wait;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Pipeline side: drives stage information, consumes hazard decisions.
  modport master (
    output ra1_d, ra2_d, ra3_d, ra1_e, ra2_e, ra3_e,
    output wa_e, wa_m, wa_w, reg_write_e, reg_write_m, reg_write_w,
    output mem_reg_e, pc_src_d, pc_src_w, branch_taken_e,
    input  fwd_a_e, fwd_b_e, fwd_c_e, stall_f, stall_d,
    input  flush_d, flush_e, pc_wait, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  ra1_d, ra2_d, ra3_d, ra1_e, ra2_e, ra3_e,
    input  wa_e, wa_m, wa_w, reg_write_e, reg_write_m, reg_write_w,
    input  mem_reg_e, pc_src_d, pc_src_w, branch_taken_e,
    output fwd_a_e, fwd_b_e, fwd_c_e, stall_f, stall_d,
    output flush_d, flush_e, pc_wait, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal issue; forwarding, load-use and branch handling
//   ST_PCWAIT | a PC-writing instruction is in flight; Decode is bubbled
//             | and Fetch held until that instruction reaches Writeback
module hazard_controller #(
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PCWAIT = 1'b1
  } state_t;

  localparam logic [3:0]       PC_IDX  = 4'(PC_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ldstall;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic       stall_f, stall_d, flush_d, flush_e;

  // The PC alias is read straight from the PC, so it is never forwarded.
  // Memory holds the younger result and therefore wins over Writeback.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic [3:0] wa_w,
    input logic       rw_m,
    input logic       rw_w
  );
    if (ra == PC_IDX)            return 2'b00;
    if (rw_m && (wa_m == ra))    return 2'b10;
    if (rw_w && (wa_w == ra))    return 2'b01;
    return 2'b00;
  endfunction

  // Load in Execute whose destination is read by the instruction in Decode.
  always_comb begin
    ldstall = hz.mem_reg_e && hz.reg_write_e && (hz.wa_e != PC_IDX) &&
              ((hz.wa_e == hz.ra1_d) || (hz.wa_e == hz.ra2_d) ||
               (hz.wa_e == hz.ra3_d));
  end

  // Execute-stage operand selects; forced to the register file during reset.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    fwd_c = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(hz.ra1_e, hz.wa_m, hz.wa_w, hz.reg_write_m, hz.reg_write_w);
      fwd_b = fwd_sel(hz.ra2_e, hz.wa_m, hz.wa_w, hz.reg_write_m, hz.reg_write_w);
      fwd_c = fwd_sel(hz.ra3_e, hz.wa_m, hz.wa_w, hz.reg_write_m, hz.reg_write_w);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state. A PC write is not tracked when the Decode instruction
  // is about to be flushed by a branch or held back by a load-use stall.
  // A taken branch while waiting cannot happen legally; returning to RUN
  // keeps the controller from wedging if it ever does.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (hz.pc_src_d && !hz.branch_taken_e && !ldstall) state_d = ST_PCWAIT;
      end
      ST_PCWAIT: begin
        if (hz.pc_src_w || hz.branch_taken_e) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline register enables, in strict priority order.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (hz.branch_taken_e) begin
        // The dependent instruction of any load-use is being squashed anyway.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (ldstall && (state_q == ST_RUN)) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if ((state_q == ST_PCWAIT) || hz.pc_src_d) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end else if (hz.pc_src_w) begin
        flush_d = 1'b1;
      end
    end
  end

  // Saturating statistics next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((flush_d || flush_e) && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.fwd_a_e   = fwd_a;
  assign hz.fwd_b_e   = fwd_b;
  assign hz.fwd_c_e   = fwd_c;
  assign hz.stall_f   = stall_f;
  assign hz.stall_d   = stall_d;
  assign hz.flush_d   = flush_d;
  assign hz.flush_e   = flush_e;
  assign hz.pc_wait   = (state_q == ST_PCWAIT);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage 22-bit pipelined processor (Fetch, Decode, Execute, Memory, Writeback).
- Generates operand-forwarding selects for the Execute stage, plus stall and flush enables for the inter-stage pipeline registers.
- Tracks in-flight PC writes with a registered FSM and keeps saturating hazard-statistics counters.
- Sits beside the pipeline top level. Consumes register addresses and control bits from each stage; drives the enables of the F/D and D/E registers.

Parameters:
- PC_REG, 15: register index that aliases the PC. It is never forwarded and never causes a load-use stall.
- CNT_W, 16: width of the stall and flush statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ra1_d, ra2_d, ra3_d  in  4  source register addresses of the instruction in Decode.
- ra1_e, ra2_e, ra3_e  in  4  source register addresses of the instruction in Execute.
- wa_e, wa_m, wa_w  in  4  destination register of the instruction in Execute, Memory and Writeback.
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enables per stage.
- mem_reg_e  in  1  the instruction in Execute is a load.
- pc_src_d, pc_src_w  in  1  instruction in Decode / Writeback writes the PC.
- branch_taken_e  in  1  branch resolved taken in Execute.
- fwd_a_e, fwd_b_e, fwd_c_e  out  2  Execute operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- stall_f, stall_d  out  1  hold the PC register / the F-D register.
- flush_d, flush_e  out  1  clear the F-D register / the D-E register to a bubble.
- pc_wait  out  1  FSM is in PCWAIT.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- While rst=1: all stall and flush outputs are 0 and fwd_* = 00. The FSM enters RUN and both counters clear to 0 on the edge. The same applies when rst asserts mid-PCWAIT.
- Forwarding is combinational, with zero latency. Evaluation per operand x in {1,2,3}:
  - If reg_write_m, wa_m==rax_e and rax_e!=PC_REG, select 10.
  - Else if reg_write_w, wa_w==rax_e and rax_e!=PC_REG, select 01.
  - Else select 00. Memory has priority over Writeback.
- Load-use hazard: ldstall = mem_reg_e & reg_write_e & (wa_e matches any of ra1_d, ra2_d, ra3_d) & wa_e!=PC_REG.
- FSM, two registered states:
  - RUN -> PCWAIT when pc_src_d=1, branch_taken_e=0, ldstall=0 and rst=0.
  - PCWAIT -> RUN on the edge where pc_src_w=1.
  - PCWAIT -> RUN on the edge where branch_taken_e=1, because the PC-writing instruction is older and cannot be flushed, so this case cannot occur legally. It is handled anyway for robustness.
  - Otherwise the state holds.
- Output priority (highest first), combinational from state and inputs:
  1. branch_taken_e=1: flush_d=1, flush_e=1, stall_f=0, stall_d=0. ldstall is ignored because the dependent instruction is being flushed.
  2. ldstall=1 (RUN only): stall_f=1, stall_d=1, flush_e=1, flush_d=0. A single bubble enters Execute; the stall lasts exactly one cycle per hazard.
  3. state==PCWAIT or pc_src_d=1: stall_f=1, flush_d=1, stall_d=0, flush_e=0. Bubbles enter Decode until the PC write retires.
  4. pc_src_w=1: flush_d=1, stall_f=0. Fetch resumes from the written PC next cycle.
  5. Otherwise all stall and flush outputs are 0.
- pc_wait = (state==PCWAIT).
- stall_cnt increments by 1 on each edge where stall_f=1. flush_cnt increments by 1 on each edge where flush_d|flush_e=1. Both saturate at 2^CNT_W-1 and never wrap.
- Expected latency of a PC-write instruction: from pc_src_d rising, stall_f is asserted for 4 cycles (D, E, M, W), then fetch resumes.

Test Plan:
- Forwarding priority: wa_m=3 and wa_w=3 with both writes enabled, ra1_e=3 -> fwd_a_e=10. Drop reg_write_m -> fwd_a_e=01. Set ra1_e=15 -> 00.
- Load-use: mem_reg_e=1, reg_write_e=1, wa_e=5, ra2_d=5 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. stall_cnt 0->1, flush_cnt 0->1.
- Branch overrides load-use: same as the load-use case plus branch_taken_e=1 -> flush_d=flush_e=1, stall_f=0.
- PC write sequence: pulse pc_src_d at cycle 0, pc_src_w at cycle 3 -> stall_f=1 and flush_d=1 in cycles 0-3, pc_wait=1 in cycles 1-3, all 0 at cycle 4, stall_cnt=4.
- Reset mid-PCWAIT: enter PCWAIT, assert rst for 1 cycle -> outputs 0 during rst, pc_wait=0 and counters=0 after the edge.
- Saturation with CNT_W=4: hold ldstall conditions for 20 cycles -> stall_cnt stops at 15.
